// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_pkg
// Shared definitions for the memory-mapped bus controller:
//   - cpu bus command encodings (MNONE/MREAD/MWRITE; code 3 behaves as MNONE)
//   - controller FSM state encoding
//   - address-region codes produced by the decoder
//   - width of the wait-state counter (wait values 0..7)
package mem_bus_pkg;

  localparam logic [1:0] MNONE  = 2'd0;
  localparam logic [1:0] MREAD  = 2'd1;
  localparam logic [1:0] MWRITE = 2'd2;

  localparam int WAIT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    R_RAM  = 2'd0,
    R_LED  = 2'd1,
    R_SW   = 2'd2,
    R_NONE = 2'd3
  } region_e;

endpackage

// File: rtl/mem_bus_ctrl_decode.sv
// mem_bus_decode
// Combinational address decoder. Maps a cpu address plus command onto a
// region code and the number of wait states that region needs.
// Ports:
//   addr_i    in   ADDR_W   cpu address
//   cmd_i     in   2        cpu command (only MREAD matters: the switch port is read-only)
//   region_o  out  region   R_RAM / R_LED / R_SW / R_NONE
//   wait_o    out  WAIT_W   extra cycles before completion for that region
module mem_bus_decode
  import mem_bus_pkg::*;
#(
  parameter int                ADDR_W   = 9,
  parameter int                RAM_WAIT = 1,
  parameter int                IO_WAIT  = 0,
  parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        cmd_i,
  output region_e           region_o,
  output logic [WAIT_W-1:0] wait_o
);

  // The lower half of the address space is RAM. In the upper half only the
  // LED register and (for reads) the switch port exist; everything else,
  // including a write to the switch port, is unmapped. Unmapped accesses
  // still complete, and take the IO wait count since they live in IO space.
  always_comb begin
    region_o = R_NONE;
    wait_o   = WAIT_W'(IO_WAIT);
    if (!addr_i[ADDR_W-1]) begin
      region_o = R_RAM;
      wait_o   = WAIT_W'(RAM_WAIT);
    end else if (addr_i == LED_ADDR) begin
      region_o = R_LED;
    end else if ((addr_i == SW_ADDR) && (cmd_i == MREAD)) begin
      region_o = R_SW;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl
// Memory-mapped bus controller between the cpu and its RAM, LED register and
// switch port. Each transaction is accepted in IDLE, optionally spends a
// number of wait cycles in WAIT, and completes with a one-cycle ready pulse
// in DONE. Unmapped accesses complete normally but set a sticky error flag.
// Ports:
//   clk        in   1        rising-edge clock
//   reset      in   1        asynchronous, active-high
//   mem_cmd    in   2        MNONE / MREAD / MWRITE (3 = MNONE)
//   mem_addr   in   ADDR_W   access address, held until ready
//   wdata      in   DATA_W   write data, held until ready
//   rdata      out  DATA_W   registered read data, valid while ready=1
//   ready      out  1        transaction-complete pulse
//   ram_addr   out  RAM_AW   RAM address (low bits of mem_addr)
//   ram_write  out  1        RAM write strobe, one cycle per write
//   ram_din    out  DATA_W   RAM write data
//   ram_dout   in   DATA_W   RAM read data (registered inside the RAM)
//   sw_in      in   IO_W     switch inputs
//   led_out    out  IO_W     LED register
//   bus_err    out  1        sticky unmapped-access flag
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 16,
  parameter int                RAM_AW   = 8,
  parameter int                RAM_WAIT = 1,
  parameter int                IO_WAIT  = 0,
  parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140,
  parameter int                IO_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic [IO_W-1:0]   sw_in,
  output logic [IO_W-1:0]   led_out,
  output logic              bus_err
);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  region_e           region_q, region_d;
  logic              isRead_q, isRead_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [IO_W-1:0]   led_q, led_d;
  logic              err_q, err_d;

  region_e           decRegion;
  logic [WAIT_W-1:0] decWait;
  logic              accept;
  logic              capture;
  region_e           capRegion;
  logic              ramWrite;

  mem_bus_decode #(
    .ADDR_W   (ADDR_W),
    .RAM_WAIT (RAM_WAIT),
    .IO_WAIT  (IO_WAIT),
    .LED_ADDR (LED_ADDR),
    .SW_ADDR  (SW_ADDR)
  ) u_decode (
    .addr_i   (mem_addr),
    .cmd_i    (mem_cmd),
    .region_o (decRegion),
    .wait_o   (decWait)
  );

  assign accept    = (state_q == IDLE) && ((mem_cmd == MREAD) || (mem_cmd == MWRITE));
  assign ready     = (state_q == DONE);
  assign ram_addr  = mem_addr[RAM_AW-1:0];
  assign ram_din   = wdata;
  assign ram_write = ramWrite;
  assign rdata     = rdata_q;
  assign led_out   = led_q;
  assign bus_err   = err_q;

  // Next-state logic. Writes take effect at the accept edge, so the RAM
  // strobe is driven straight from the decoded inputs only in the accept
  // cycle. Read data is captured on whichever edge enters DONE: the accept
  // edge itself when the region has no wait states (using the live decode),
  // otherwise the WAIT edge where the counter reaches 1 (using the latched
  // region, so address changes during WAIT are ignored).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    region_d  = region_q;
    isRead_d  = isRead_q;
    rdata_d   = rdata_q;
    led_d     = led_q;
    err_d     = err_q;
    ramWrite  = 1'b0;
    capture   = 1'b0;
    capRegion = region_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          region_d  = decRegion;
          isRead_d  = (mem_cmd == MREAD);
          cnt_d     = decWait;
          state_d   = (decWait != '0) ? WAIT : DONE;
          capture   = (mem_cmd == MREAD) && (decWait == '0);
          capRegion = decRegion;
          if (mem_cmd == MWRITE) begin
            if (decRegion == R_RAM) ramWrite = 1'b1;
            if (decRegion == R_LED) led_d = wdata[IO_W-1:0];
          end
          if (decRegion == R_NONE) err_d = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == WAIT_W'(1)) begin
          state_d = DONE;
          capture = isRead_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (capture) begin
      case (capRegion)
        R_RAM:   rdata_d = ram_dout;
        R_LED:   rdata_d = DATA_W'(led_q);
        R_SW:    rdata_d = DATA_W'(sw_in);
        default: rdata_d = '0;
      endcase
    end
  end

  // State and data registers. Reset abandons any transaction in flight and
  // clears the visible registers; RAM contents live outside and are kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      region_q <= R_NONE;
      isRead_q <= 1'b0;
      rdata_q  <= '0;
      led_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      region_q <= region_d;
      isRead_q <= isRead_d;
      rdata_q  <= rdata_d;
      led_q    <= led_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl
// Self-checking bench for mem_bus_ctrl. A registered-read RAM sits beside
// the main controller (RAM_WAIT=1, IO_WAIT=0). The expected behaviour comes
// from a small reference model: an array of memory words, the LED value,
// the error flag and the last read value, updated per transaction.
// Four extra controllers with RAM_WAIT=0..3 are used only to measure latency.
module tb_mem_bus_ctrl;

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ready;
  logic [7:0]  ram_addr;
  logic        ram_write;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic [9:0]  sw_in;
  logic [9:0]  led_out;
  logic        bus_err;

  logic [1:0]  swCmd;
  logic [15:0] swRdata   [4];
  logic        swReady   [4];
  logic [7:0]  swRamAddr [4];
  logic        swRamWr   [4];
  logic [15:0] swRamDin  [4];
  logic [9:0]  swLed     [4];
  logic        swErr     [4];

  logic [15:0] ramMem [256] = '{default: 16'h0000};
  logic [15:0] refMem [256] = '{default: 16'h0000};
  logic [9:0]  refLed;
  logic        refErr;
  logic [15:0] refRdata;

  int compareCount = 0;
  int failCount    = 0;

  mem_bus_ctrl #(.RAM_WAIT(1), .IO_WAIT(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .ram_addr  (ram_addr),
    .ram_write (ram_write),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .bus_err   (bus_err)
  );

  // Latency-sweep controllers, one per RAM wait count.
  for (genvar g = 0; g < 4; g++) begin : gSweep
    mem_bus_ctrl #(.RAM_WAIT(g), .IO_WAIT(0)) swDut (
      .clk       (clk),
      .reset     (reset),
      .mem_cmd   (swCmd),
      .mem_addr  (mem_addr),
      .wdata     (wdata),
      .rdata     (swRdata[g]),
      .ready     (swReady[g]),
      .ram_addr  (swRamAddr[g]),
      .ram_write (swRamWr[g]),
      .ram_din   (swRamDin[g]),
      .ram_dout  (16'h0000),
      .sw_in     (10'h000),
      .led_out   (swLed[g]),
      .bus_err   (swErr[g])
    );
  end

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM attached to the main controller.
  always @(posedge clk) begin
    if (ram_write) ramMem[ram_addr] <= ram_din;
    ram_dout <= ramMem[ram_addr];
  end

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full transaction on the main controller, checked against the model.
  // swapAddr changes mem_addr after the accept edge to show it is ignored.
  task automatic applyStimulus(input logic [1:0] cmd, input logic [8:0] addr,
                               input logic [15:0] data, input logic [9:0] sw,
                               input bit swapAddr);
    int          lat;
    int          expLat;
    bit          isRam, isLed, isSw;
    logic [15:0] expR;

    @(negedge clk);
    mem_cmd  = cmd;
    mem_addr = addr;
    wdata    = data;
    sw_in    = sw;
    #1;
    checkOutput("strobe_accept", ram_write, (cmd == CMD_WRITE) && !addr[8]);

    isRam  = !addr[8];
    isLed  = (addr == 9'h100);
    isSw   = (addr == 9'h140) && (cmd == CMD_READ);
    expLat = isRam ? 2 : 1;
    expR   = refRdata;
    if (cmd == CMD_READ) begin
      if (isRam)      expR = refMem[addr[7:0]];
      else if (isLed) expR = {6'b0, refLed};
      else if (isSw)  expR = {6'b0, sw};
      else            expR = 16'h0000;
    end else begin
      if (isRam)      refMem[addr[7:0]] = data;
      else if (isLed) refLed = data[9:0];
    end
    if (!isRam && !isLed && !isSw) refErr = 1'b1;
    refRdata = expR;

    @(posedge clk);
    #1;
    lat = 1;
    if (swapAddr) mem_addr = addr + 9'd1;
    while (!ready && lat < 20) begin
      checkOutput("strobe_wait", ram_write, 1'b0);
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", lat, expLat);
    checkOutput("rdata", rdata, expR);
    checkOutput("led_out", led_out, refLed);
    checkOutput("bus_err", bus_err, refErr);
    mem_cmd = CMD_NONE;
    @(posedge clk);
  endtask

  initial begin
    int lat [4];
    int pick;
    logic [8:0] a;

    reset    = 1'b1;
    mem_cmd  = CMD_NONE;
    swCmd    = CMD_NONE;
    mem_addr = 9'h000;
    wdata    = 16'h0000;
    sw_in    = 10'h000;
    refLed   = '0;
    refErr   = 1'b0;
    refRdata = '0;

    #12;
    checkOutput("rst_rdata", rdata, 16'h0000);
    checkOutput("rst_ready", ready, 1'b0);
    checkOutput("rst_ram_write", ram_write, 1'b0);
    checkOutput("rst_led", led_out, 10'h000);
    checkOutput("rst_err", bus_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);

    // RAM write then read-back.
    applyStimulus(CMD_WRITE, 9'h005, 16'hBEEF, 10'h000, 0);
    applyStimulus(CMD_READ,  9'h005, 16'h0000, 10'h000, 0);

    // LED write, switch read.
    applyStimulus(CMD_WRITE, 9'h100, 16'h02AA, 10'h000, 0);
    applyStimulus(CMD_READ,  9'h140, 16'h0000, 10'h155, 0);
    applyStimulus(CMD_READ,  9'h100, 16'h0000, 10'h000, 0);

    // Unmapped read and write to the read-only switch port.
    applyStimulus(CMD_READ,  9'h1F0, 16'h0000, 10'h000, 0);
    applyStimulus(CMD_WRITE, 9'h140, 16'h0333, 10'h000, 0);

    // Address change during WAIT is ignored.
    applyStimulus(CMD_WRITE, 9'h006, 16'h1234, 10'h000, 0);
    applyStimulus(CMD_READ,  9'h005, 16'h0000, 10'h000, 1);

    // Command code 3 is a no-op.
    @(negedge clk);
    mem_cmd  = 2'd3;
    mem_addr = 9'h1F0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("cmd3_ready", ready, 1'b0);
      checkOutput("cmd3_strobe", ram_write, 1'b0);
    end
    mem_cmd = CMD_NONE;

    // Reset in the middle of a RAM read.
    @(negedge clk);
    mem_cmd  = CMD_READ;
    mem_addr = 9'h005;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    mem_cmd  = CMD_NONE;
    refLed   = '0;
    refErr   = 1'b0;
    refRdata = '0;
    checkOutput("midrst_ready", ready, 1'b0);
    checkOutput("midrst_led", led_out, 10'h000);
    checkOutput("midrst_err", bus_err, 1'b0);
    checkOutput("midrst_rdata", rdata, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    applyStimulus(CMD_READ, 9'h005, 16'h0000, 10'h000, 0);

    // Back-to-back reads: completion every third cycle.
    @(negedge clk);
    mem_cmd  = CMD_READ;
    mem_addr = 9'h005;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      checkOutput("b2b_ready", ready, (i % 3) == 1);
      if (ready) checkOutput("b2b_rdata", rdata, refMem[5]);
    end
    mem_cmd  = CMD_NONE;
    refRdata = refMem[5];
    @(posedge clk);

    // Latency sweep across RAM wait counts 0..3.
    @(negedge clk);
    swCmd    = CMD_READ;
    mem_addr = 9'h005;
    for (int g = 0; g < 4; g++) lat[g] = 0;
    @(posedge clk);
    #1;
    swCmd = CMD_NONE;
    for (int c = 1; c <= 8; c++) begin
      for (int g = 0; g < 4; g++)
        if (lat[g] == 0 && swReady[g]) lat[g] = c;
      @(posedge clk);
      #1;
    end
    for (int g = 0; g < 4; g++) checkOutput("sweep_latency", lat[g], 1 + g);

    // Randomized transactions across all regions.
    for (int n = 0; n < 80; n++) begin
      pick = $urandom_range(0, 5);
      case (pick)
        0, 1, 2: a = {5'b0, 4'($urandom_range(0, 15))};
        3:       a = 9'h100;
        4:       a = 9'h140;
        default: a = 9'h180 | 9'($urandom_range(0, 127));
      endcase
      applyStimulus(2'($urandom_range(1, 2)), a, 16'($urandom), 10'($urandom), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
